// File: rtl/uart_tx_engine_if.sv
// Bundle between the UART register block (master) and the transmit engine (slave).
// state_dbg mirrors the engine FSM encoding so checkers can follow frame progress.
interface uart_tx_engine_if #(
  parameter int DIV_W = 16
);
  logic             en;
  logic             start;
  logic [7:0]       data;
  logic [DIV_W-1:0] baud_div;
  logic             parity_en;
  logic             parity_odd;
  logic             two_stop;
  logic             tx;
  logic             busy;
  logic             done;
  logic [2:0]       state_dbg;

  modport master (
    output en, start, data, baud_div, parity_en, parity_odd, two_stop,
    input  tx, busy, done, state_dbg
  );

  modport slave (
    input  en, start, data, baud_div, parity_en, parity_odd, two_stop,
    output tx, busy, done, state_dbg
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one byte per accepted start with optional
// parity and one or two stop bits. All outputs are registered.
module uart_tx_engine #(
  parameter int DIV_W = 16
) (
  input logic             clk,
  input logic             rst,
  uart_tx_engine_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [DIV_W-1:0] cnt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [7:0]       sh_data;
  logic [DIV_W-1:0] sh_div;
  logic             sh_par_en;
  logic             sh_par_odd;
  logic             sh_two_stop;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;

  assign idx_nxt = idx + 3'd1;

  // Handshake: start is a one-cycle request, taken only when en=1 and the
  // engine is idle; busy=1 means any start is dropped, never queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh_data     <= '0;
      sh_div      <= '0;
      sh_par_en   <= 1'b0;
      sh_par_odd  <= 1'b0;
      sh_two_stop <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!bus.en) begin
        // Abort: shadows are left untouched on purpose
        state  <= S_IDLE;
        cnt    <= '0;
        idx    <= '0;
        tx_q   <= 1'b1;
        busy_q <= 1'b0;
      end else if (state == S_IDLE) begin
        if (bus.start) begin
          sh_data     <= bus.data;
          sh_div      <= bus.baud_div;
          sh_par_en   <= bus.parity_en;
          sh_par_odd  <= bus.parity_odd;
          sh_two_stop <= bus.two_stop;
          cnt         <= '0;
          idx         <= '0;
          state       <= S_START;
          tx_q        <= 1'b0;
          busy_q      <= 1'b1;
        end
      end else if (cnt != sh_div) begin
        cnt <= cnt + CNT_ONE;
      end else begin
        // Bit period ends: tx is loaded with the next bit on the same edge
        cnt <= '0;
        case (state)
          S_START: begin
            state <= S_DATA;
            idx   <= '0;
            tx_q  <= sh_data[0];
          end
          S_DATA: begin
            if (idx == 3'd7) begin
              idx <= '0;
              if (sh_par_en) begin
                state <= S_PARITY;
                tx_q  <= (^sh_data) ^ sh_par_odd;
              end else begin
                state <= S_STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              idx  <= idx_nxt;
              tx_q <= sh_data[idx_nxt];
            end
          end
          S_PARITY: begin
            state <= S_STOP;
            idx   <= '0;
            tx_q  <= 1'b1;
          end
          S_STOP: begin
            if (sh_two_stop && (idx == 3'd0)) begin
              idx <= 3'd1;
            end else begin
              state  <= S_IDLE;
              idx    <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
            tx_q <= 1'b1;
          end
          default: begin
            state  <= S_IDLE;
            idx    <= '0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: table of frames with hand-computed bit
// sequences, plus reset, abort, mid-frame input changes and back-to-back.
module tb_uart_tx_engine;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        pen;
    logic        podd;
    logic        two;
    int          nbits;
    logic [11:0] bits;   // bits[k] is frame bit k, start bit at k=0
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;
  vec_t vecs[6];
  logic [0:0] exp_q[$];

  uart_tx_engine_if #(.DIV_W(16)) u_if ();

  uart_tx_engine #(.DIV_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (u_if.done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: load inputs, pulse start; returns in cycle 0 of the frame
  task automatic launch(input int vi);
    u_if.data       = vecs[vi].data;
    u_if.baud_div   = vecs[vi].div;
    u_if.parity_en  = vecs[vi].pen;
    u_if.parity_odd = vecs[vi].podd;
    u_if.two_stop   = vecs[vi].two;
    u_if.start      = 1'b1;
    step();
    u_if.start      = 1'b0;
  endtask

  // scoreboard: checks every cycle of the frame, ends in the done cycle
  task automatic check_frame(input int vi, input bit mid);
    int n;
    logic [0:0] e;
    n = int'(vecs[vi].div) + 1;
    for (int k = 0; k < vecs[vi].nbits; k++) exp_q.push_back(vecs[vi].bits[k]);
    for (int k = 0; k < vecs[vi].nbits; k++) begin
      e = exp_q.pop_front();
      for (int j = 0; j < n; j++) begin
        chk($sformatf("v%0d_tx_bit%0d", vi, k), u_if.tx, e);
        chk($sformatf("v%0d_busy_bit%0d", vi, k), u_if.busy, 1'b1);
        chk($sformatf("v%0d_done_bit%0d", vi, k), u_if.done, 1'b0);
        if (mid && k == 3 && j == 0) begin
          u_if.data     = 8'hFF;
          u_if.baud_div = 16'd9;
          u_if.start    = 1'b1;
        end else begin
          u_if.start    = 1'b0;
        end
        step();
      end
    end
    chk($sformatf("v%0d_done_pulse", vi), u_if.done, 1'b1);
    chk($sformatf("v%0d_busy_end", vi), u_if.busy, 1'b0);
    chk($sformatf("v%0d_tx_end", vi), u_if.tx, 1'b1);
  endtask

  initial begin
    int d0;
    vecs[0] = '{8'hA5, 16'd3, 1'b0, 1'b0, 1'b0, 10, 12'b001101001010};
    vecs[1] = '{8'h07, 16'd0, 1'b1, 1'b0, 1'b1, 12, 12'b111000001110};
    vecs[2] = '{8'h07, 16'd0, 1'b1, 1'b1, 1'b1, 12, 12'b110000001110};
    vecs[3] = '{8'h3C, 16'd1, 1'b1, 1'b0, 1'b0, 11, 12'b010001111000};
    vecs[4] = '{8'h00, 16'd2, 1'b1, 1'b1, 1'b1, 12, 12'b111000000000};
    vecs[5] = '{8'hFF, 16'd0, 1'b0, 1'b0, 1'b1, 11, 12'b011111111110};
    checks = 0; errors = 0; done_cnt = 0;

    // reset held with start asserted
    rst = 1'b1;
    u_if.en = 1'b1; u_if.start = 1'b1; u_if.data = 8'hA5; u_if.baud_div = 16'd3;
    u_if.parity_en = 1'b0; u_if.parity_odd = 1'b0; u_if.two_stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx", u_if.tx, 1'b1);
      chk("rst_busy", u_if.busy, 1'b0);
      chk("rst_done", u_if.done, 1'b0);
    end
    rst = 1'b0; u_if.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_state", u_if.state_dbg, 3'd0);
      chk("post_rst_busy", u_if.busy, 1'b0);
      chk("post_rst_tx", u_if.tx, 1'b1);
    end

    // table of frames
    for (int vi = 0; vi < 6; vi++) begin
      d0 = done_cnt;
      launch(vi);
      check_frame(vi, 1'b0);
      step();
      chk($sformatf("v%0d_done_one_cycle", vi), u_if.done, 1'b0);
      chk($sformatf("v%0d_idle_tx", vi), u_if.tx, 1'b1);
      chk($sformatf("v%0d_done_count", vi), done_cnt, d0 + 1);
    end

    // inputs change and start pulses mid-frame
    d0 = done_cnt;
    launch(0);
    check_frame(0, 1'b1);
    step();
    step();
    chk("mid_done_count", done_cnt, d0 + 1);
    chk("mid_busy_after", u_if.busy, 1'b0);

    // start with en low is ignored
    u_if.en = 1'b0; u_if.start = 1'b1;
    step();
    u_if.start = 1'b0; u_if.en = 1'b1;
    chk("en_low_start_busy", u_if.busy, 1'b0);
    step();
    chk("en_low_start_tx", u_if.tx, 1'b1);

    // abort in DATA, then a clean frame
    d0 = done_cnt;
    launch(0);
    for (int i = 0; i < 9; i++) step();
    chk("abort_in_data", u_if.state_dbg, 3'd2);
    u_if.en = 1'b0;
    step();
    chk("abort_tx", u_if.tx, 1'b1);
    chk("abort_busy", u_if.busy, 1'b0);
    for (int i = 0; i < 45; i++) step();
    chk("abort_no_done", done_cnt, d0);
    u_if.en = 1'b1;
    launch(3);
    check_frame(3, 1'b0);
    step();
    chk("after_abort_done_count", done_cnt, d0 + 1);

    // reset during a frame
    launch(0);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_tx", u_if.tx, 1'b1);
    chk("rst_mid_busy", u_if.busy, 1'b0);
    step();

    // back-to-back: second start issued in the done cycle
    d0 = done_cnt;
    launch(3);
    check_frame(3, 1'b0);
    launch(3);
    check_frame(3, 1'b0);
    step();
    chk("b2b_done_count", done_cnt, d0 + 2);
    chk("b2b_idle_busy", u_if.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmit engine for the SoC UART. It sits directly downstream of the AHB-Lite UART register block, which drives it with enable, start pulse, data byte and baud divisor, and it drives the `tx` pin. It serialises one byte per start request with configurable parity and stop-bit count. It reports `busy` and a one-cycle `done`, which the register block uses to update its status bit.

## Interface
Parameters:
- `DIV_W`, default 16: width of the baud divisor.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `en`  in  1  engine enable. Low aborts any frame and holds the engine idle.
- `start`  in  1  single-cycle request to send `data`.
- `data`  in  8  byte to send. Captured when `start` is accepted.
- `baud_div`  in  DIV_W  bit period is `baud_div`+1 clk cycles. Captured when `start` is accepted.
- `parity_en`  in  1  inserts a parity bit after the data bits. Captured when `start` is accepted.
- `parity_odd`  in  1  0 selects even parity, 1 selects odd. Captured when `start` is accepted.
- `two_stop`  in  1  0 selects one stop bit, 1 selects two. Captured when `start` is accepted.
- `tx`  out  1  serial line. Idles high.
- `busy`  out  1  high while a frame is in progress.
- `done`  out  1  one-cycle pulse when a frame completes normally.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx`=1 and `busy`=0.
  - `start`=1 with `en`=1 is accepted. On acceptance the engine:
    - latches `data`, `baud_div`, `parity_en`, `parity_odd` and `two_stop` into shadow registers;
    - clears the baud counter and the bit index;
    - moves to START.
- **START**: drives `tx`=0 for one bit period, then moves to DATA.
- **DATA**
  - Drives shadow bit[idx], LSB first, with idx running 0..7.
  - After the period for idx=7 it moves to PARITY if parity_en is set, otherwise to STOP.
- **PARITY**
  - Drives the XOR of the 8 shadow data bits, XORed with parity_odd.
  - Lasts one bit period, then moves to STOP.
- **STOP**
  - Drives `tx`=1 for one bit period, or two when two_stop is set.
  - Then moves to IDLE and pulses `done`.
- **Baud counter**
  - DIV_W-bit counter that counts 0..shadow_div.
  - A bit period ends in the cycle where counter == shadow_div. In that cycle the counter returns to 0 and the FSM advances.
  - shadow_div=0 gives one cycle per bit. shadow_div=2^DIV_W−1 gives 2^DIV_W cycles per bit.
  - The counter never wraps past shadow_div.
- **Parity** is computed from the shadow byte, not from the live `data` input.
- Frame bit count B = 10 + parity_en + two_stop. Frame length is B·(shadow_div+1) cycles.
- **Input changes during a frame**
  - `start` while `busy`=1 is ignored. It is neither queued nor able to corrupt the frame.
  - Changes on `data`, `baud_div` or the config inputs during a frame have no effect on that frame.
- **`en` low mid-frame**: on the next edge the FSM goes to IDLE and `tx`=1. No `done` is produced. The shadow registers keep their values.
- **`start` and `en` falling together in IDLE**: the request is ignored.

## Timing
- **Reset**: `tx`=1, `busy`=0, `done`=0, FSM in IDLE, counter=0, idx=0, shadow registers=0.
  - `rst` overrides everything, including an active frame; `tx` returns to 1 on the next edge.
- **Start acceptance and frame duration**: with `start` sampled high at edge T:
  - from edge T, `tx`=0 and `busy`=1;
  - the start bit occupies cycles T..T+N−1, where N = shadow_div+1;
  - bit k of the frame occupies cycles T+k·N..T+(k+1)·N−1.
- **Frame end**: at edge T+B·N the FSM enters IDLE.
  - `busy` falls and `done` rises.
  - `done` is high for exactly one cycle.
- **Back-to-back frames**
  - A `start` sampled in the same cycle that `done` is high is accepted.
  - The next start bit then begins at the following edge, with zero idle time between frames.
- All outputs are registered. There is no combinational path from any input to `tx`, `busy` or `done`.

## Test plan
- **Reset**: hold `rst` for 3 cycles while driving `start`=1 -> `tx`=1, `busy`=0 and `done`=0 throughout; no frame begins after release until a fresh `start`.
- **Basic frame**
  - Stimulus: `en`=1, `baud_div`=3, `data`=0xA5, no parity, one stop bit, one-cycle `start`.
  - `tx` over 4-cycle bits reads 0,1,0,1,0,0,1,0,1,1.
  - `done` pulses 40 cycles after acceptance; `busy` is high for exactly 40 cycles.
- **Parity and two stop bits**
  - Stimulus: `data`=0x07, `parity_en`=1, `parity_odd`=0, `two_stop`=1, `baud_div`=0.
  - Frame is 0,1,1,1,0,0,0,0,0,1,1,1. The parity bit is 1.
  - `done` pulses at cycle 12.
  - Repeat with `parity_odd`=1 -> parity bit is 0.
- **Input changes mid-frame**: change `data` to 0xFF and `baud_div` to 9, and pulse `start`, in the middle of the 0xA5 frame -> waveform is identical to the basic-frame case and exactly one `done` is produced.
- **Abort**: drop `en` during the DATA state -> `tx`=1 and `busy`=0 on the next cycle; no `done` is produced. Re-enable and start 0x3C -> a correct frame is sent.
- **Back-to-back**
  - Stimulus: assert `start` in the `done` cycle, with `baud_div`=1.
  - The second start bit immediately follows the stop bit, with no idle cycles.
  - `done` is produced once per frame.
